// File: rtl/jzjpcc_mmio_if.sv
// Data-side memory bus between the CPU core and the MMIO register block.
// Single-cycle request, load response exactly one cycle later, no backpressure.
interface jzjpcc_mmio_if;
  logic        memRequest;
  logic        memWriteEnable;
  logic [31:2] memAddress;
  logic [3:0]  memByteEnable;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;
  logic        memReadValid;

  modport master (
    output memRequest, memWriteEnable, memAddress, memByteEnable, memWriteData,
    input  memReadData, memReadValid
  );

  modport slave (
    input  memRequest, memWriteEnable, memAddress, memByteEnable, memWriteData,
    output memReadData, memReadValid
  );
endinterface

// File: rtl/jzjpcc_mmio.sv
// MMIO block: 32-bit GPIO port A (out/in/dir) and a compare-match timer behind an
// 8-word register window. Loads answer one cycle later; stores take effect at the edge.
module jzjpcc_mmio #(
  parameter logic [31:0] MMIO_BASE   = 32'hFFFFFFE0,
  parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
  input  logic                 clock,
  input  logic                 reset,
  jzjpcc_mmio_if.slave         bus,
  input  logic [31:0]          portAIn,
  output logic [31:0]          portAOut,
  output logic [31:0]          portADir,
  output logic                 timerIrq
);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

  logic [31:0] porta_out_q, porta_out_d;
  logic [31:0] porta_dir_q, porta_dir_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic        flag_q, flag_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [SYNC_STAGES-1:0][31:0] sync_q;

  logic        sel, wr, rd, match;
  logic [2:0]  offset;
  logic [31:0] rd_mux;

  assign sel    = bus.memRequest && (bus.memAddress[31:5] == MMIO_BASE[31:5]);
  assign wr     = sel && bus.memWriteEnable;
  assign rd     = sel && !bus.memWriteEnable;
  assign offset = bus.memAddress[4:2];
  assign match  = en_q && (count_q == compare_q);

  always_comb begin
    rd_mux = 32'd0;
    case (offset)
      3'd0:    rd_mux = porta_out_q;
      3'd1:    rd_mux = sync_q[SYNC_STAGES-1];
      3'd2:    rd_mux = porta_dir_q;
      3'd3:    rd_mux = count_q;
      3'd4:    rd_mux = compare_q;
      3'd5:    rd_mux = {29'd0, flag_q, irq_en_q, en_q};
      default: rd_mux = 32'd0;
    endcase
  end

  always_comb begin
    porta_out_d = porta_out_q;
    porta_dir_d = porta_dir_q;
    compare_d   = compare_q;
    en_d        = en_q;
    irq_en_d    = irq_en_q;
    flag_d      = flag_q;
    rd_valid_d  = rd;
    rd_data_d   = rd ? rd_mux : 32'd0;

    if (!en_q) begin
      count_d = count_q;
    end else if (match) begin
      count_d = 32'd0;
    end else begin
      count_d = count_q + 32'd1;
    end

    if (wr) begin
      case (offset)
        3'd0: porta_out_d = merge_bytes(porta_out_q, bus.memWriteData, bus.memByteEnable);
        3'd2: porta_dir_d = merge_bytes(porta_dir_q, bus.memWriteData, bus.memByteEnable);
        // Unwritten lanes keep the value the timer would have produced anyway.
        3'd3: count_d     = merge_bytes(count_d, bus.memWriteData, bus.memByteEnable);
        3'd4: compare_d   = merge_bytes(compare_q, bus.memWriteData, bus.memByteEnable);
        3'd5: begin
          if (bus.memByteEnable[0]) begin
            en_d     = bus.memWriteData[0];
            irq_en_d = bus.memWriteData[1];
            if (bus.memWriteData[2]) flag_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // A match in the same cycle as a W1C keeps the flag set.
    if (match) flag_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      porta_out_q <= 32'd0;
      porta_dir_q <= 32'd0;
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      en_q        <= 1'b0;
      irq_en_q    <= 1'b0;
      flag_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= 32'd0;
      sync_q      <= '0;
    end else begin
      porta_out_q <= porta_out_d;
      porta_dir_q <= porta_dir_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      en_q        <= en_d;
      irq_en_q    <= irq_en_d;
      flag_q      <= flag_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], portAIn};
    end
  end

  assign bus.memReadValid = rd_valid_q;
  assign bus.memReadData  = rd_data_q;
  assign portAOut         = porta_out_q;
  assign portADir         = porta_dir_q;
  assign timerIrq         = flag_q & irq_en_q;

endmodule
